// File: rtl/input_manager_pkg.sv
// Shared timing constants for the player input block.
// DAS defaults are in frame ticks.
package input_manager_pkg;

  localparam int DAS_DELAY_DEF = 16;
  localparam int DAS_SPEED_DEF = 4;
  localparam int TIMER_W_DEF   = 6;

  // Timer value at which an auto-repeat fires; the timer is reloaded from here.
  function automatic int das_fire_point(input int delay, input int speed);
    return delay + speed;
  endfunction

endpackage

// File: rtl/input_manager_das_channel.sv
// One delayed-auto-shift key channel.
// It gives an immediate pulse on press, then paced repeats while the key is held.
module das_channel
  import input_manager_pkg::*;
#(
  parameter int DAS_DELAY = DAS_DELAY_DEF,
  parameter int DAS_SPEED = DAS_SPEED_DEF,
  parameter int TIMER_W   = TIMER_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic raw,
  output logic cmd
);

  localparam logic [TIMER_W-1:0] FIRE   = TIMER_W'(das_fire_point(DAS_DELAY, DAS_SPEED));
  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(DAS_DELAY + 1);

  logic               prev;
  logic [TIMER_W-1:0] timer;
  logic               press;

  assign press = raw & ~prev;

  // The timer is reloaded below FIRE on every repeat, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      timer <= '0;
      cmd   <= 1'b0;
    end else begin
      prev <= raw;
      if (!raw) begin
        timer <= '0;
        cmd   <= 1'b0;
      end else if (press) begin
        timer <= '0;
        cmd   <= 1'b1;
      end else if (tick_game) begin
        if (timer == FIRE) begin
          timer <= RELOAD;
          cmd   <= 1'b1;
        end else begin
          timer <= timer + TIMER_W'(1);
          cmd   <= 1'b0;
        end
      end else begin
        cmd <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/input_manager.sv
// Turns debounced key levels into single-cycle game commands.
// Rotate and drop are one-shot keys; left, right and down auto-repeat.
module input_manager
  import input_manager_pkg::*;
#(
  parameter int DAS_DELAY = DAS_DELAY_DEF,
  parameter int DAS_SPEED = DAS_SPEED_DEF,
  parameter int TIMER_W   = TIMER_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_down,
  input  logic raw_rotate,
  input  logic raw_drop,
  output logic cmd_left,
  output logic cmd_right,
  output logic cmd_down,
  output logic cmd_rotate,
  output logic cmd_drop
);

  logic prev_rotate;
  logic prev_drop;

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_SPEED(DAS_SPEED), .TIMER_W(TIMER_W)) u_left (
    .clk(clk), .rst(rst), .tick_game(tick_game), .raw(raw_left), .cmd(cmd_left)
  );

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_SPEED(DAS_SPEED), .TIMER_W(TIMER_W)) u_right (
    .clk(clk), .rst(rst), .tick_game(tick_game), .raw(raw_right), .cmd(cmd_right)
  );

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_SPEED(DAS_SPEED), .TIMER_W(TIMER_W)) u_down (
    .clk(clk), .rst(rst), .tick_game(tick_game), .raw(raw_down), .cmd(cmd_down)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_rotate <= 1'b0;
      prev_drop   <= 1'b0;
      cmd_rotate  <= 1'b0;
      cmd_drop    <= 1'b0;
    end else begin
      prev_rotate <= raw_rotate;
      prev_drop   <= raw_drop;
      cmd_rotate  <= raw_rotate & ~prev_rotate;
      cmd_drop    <= raw_drop & ~prev_drop;
    end
  end

endmodule

// File: tb/tb_input_manager.sv
// Directed self-checking bench for input_manager.
// The command vector is ordered {left, right, down, rotate, drop}.
module tb_input_manager;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_game = 1'b0;
  logic raw_left = 1'b0, raw_right = 1'b0, raw_down = 1'b0;
  logic raw_rotate = 1'b0, raw_drop = 1'b0;
  logic cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop;
  logic [4:0] cmds;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign cmds = {cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop};

  always #5 clk = ~clk;

  input_manager dut (
    .clk(clk), .rst(rst), .tick_game(tick_game),
    .raw_left(raw_left), .raw_right(raw_right), .raw_down(raw_down),
    .raw_rotate(raw_rotate), .raw_drop(raw_drop),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_down(cmd_down),
    .cmd_rotate(cmd_rotate), .cmd_drop(cmd_drop)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One isolated tick: high for one cycle, low for one cycle.
  task automatic tick(output logic [4:0] at_tick, output logic [4:0] after);
    tick_game = 1'b1;
    step();
    at_tick = cmds;
    tick_game = 1'b0;
    step();
    after = cmds;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    total_cnt++;
    if (cmds !== 5'b00000) $display("FAIL reset_cmds: got %b expected %b", cmds, 5'b00000);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if (cmds !== 5'b00000) $display("FAIL idle_after_reset: got %b expected %b", cmds, 5'b00000);
    else pass_cnt++;
  endtask

  task automatic test_rotate;
    raw_rotate = 1'b1;
    step();
    total_cnt++;
    if (cmds !== 5'b00010) $display("FAIL rotate_press: got %b expected %b", cmds, 5'b00010);
    else pass_cnt++;
    for (int i = 0; i < 11; i++) begin
      step();
      total_cnt++;
      if (cmds !== 5'b00000) $display("FAIL rotate_hold[%0d]: got %b expected %b", i, cmds, 5'b00000);
      else pass_cnt++;
    end
    raw_rotate = 1'b0;
    step();
    total_cnt++;
    if (cmds !== 5'b00000) $display("FAIL rotate_release: got %b expected %b", cmds, 5'b00000);
    else pass_cnt++;
    raw_rotate = 1'b1;
    step();
    total_cnt++;
    if (cmds !== 5'b00010) $display("FAIL rotate_repress: got %b expected %b", cmds, 5'b00010);
    else pass_cnt++;
    step();
    total_cnt++;
    if (cmds !== 5'b00000) $display("FAIL rotate_repress_end: got %b expected %b", cmds, 5'b00000);
    else pass_cnt++;
    raw_rotate = 1'b0;
    step();
  endtask

  task automatic test_left_das;
    logic [4:0] a, b;
    raw_left = 1'b1;
    step();
    total_cnt++;
    if (cmds !== 5'b10000) $display("FAIL left_press: got %b expected %b", cmds, 5'b10000);
    else pass_cnt++;
    for (int k = 1; k <= 20; k++) begin
      tick(a, b);
      total_cnt++;
      if ({a, b} !== 10'b0) $display("FAIL left_delay tick %0d: got %b/%b expected 00000/00000", k, a, b);
      else pass_cnt++;
    end
  endtask

  task automatic test_left_repeat;
    logic [4:0] a, b;
    logic exp;
    for (int k = 21; k <= 31; k++) begin
      exp = (k == 21) || (k == 25) || (k == 29);
      tick(a, b);
      total_cnt++;
      if (a !== {exp, 4'b0000} || b !== 5'b00000)
        $display("FAIL left_repeat tick %0d: got %b/%b expected %b/00000", k, a, b, {exp, 4'b0000});
      else pass_cnt++;
    end
    raw_left = 1'b0;
    step();
    total_cnt++;
    if (cmds !== 5'b00000) $display("FAIL left_release: got %b expected %b", cmds, 5'b00000);
    else pass_cnt++;
  endtask

  task automatic test_release_resets_timer;
    logic [4:0] a, b;
    raw_left = 1'b1;
    step();
    total_cnt++;
    if (cmd_left !== 1'b1) $display("FAIL rel_press1: got %b expected 1", cmd_left);
    else pass_cnt++;
    for (int k = 1; k <= 18; k++) tick(a, b);
    raw_left = 1'b0;
    step();
    raw_left = 1'b1;
    step();
    total_cnt++;
    if (cmds !== 5'b10000) $display("FAIL rel_repress: got %b expected %b", cmds, 5'b10000);
    else pass_cnt++;
    for (int k = 1; k <= 21; k++) begin
      tick(a, b);
      total_cnt++;
      if (a[4] !== (k == 21) || b[4] !== 1'b0)
        $display("FAIL rel_timer tick %0d: got %b/%b expected %b/0", k, a[4], b[4], (k == 21));
      else pass_cnt++;
    end
    raw_left = 1'b0;
    step();
  endtask

  task automatic test_independence;
    logic [4:0] a, b;
    raw_right = 1'b1;
    raw_drop = 1'b1;
    step();
    total_cnt++;
    if (cmds !== 5'b01001) $display("FAIL right_drop_press: got %b expected %b", cmds, 5'b01001);
    else pass_cnt++;
    step();
    total_cnt++;
    if (cmds !== 5'b00000) $display("FAIL right_drop_end: got %b expected %b", cmds, 5'b00000);
    else pass_cnt++;
    raw_right = 1'b0;
    raw_down = 1'b1;
    step();
    total_cnt++;
    if (cmds !== 5'b00100) $display("FAIL down_press: got %b expected %b", cmds, 5'b00100);
    else pass_cnt++;
    for (int k = 1; k <= 21; k++) begin
      tick(a, b);
      total_cnt++;
      if (a !== {2'b00, (k == 21), 2'b00} || b !== 5'b00000)
        $display("FAIL down_repeat tick %0d: got %b/%b expected %b/00000", k, a, b, {2'b00, (k == 21), 2'b00});
      else pass_cnt++;
    end
    raw_down = 1'b0;
    raw_drop = 1'b0;
    step();
  endtask

  task automatic test_async_reset;
    logic [4:0] a, b;
    raw_left = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) tick(a, b);
    raw_rotate = 1'b1;
    step();
    total_cnt++;
    if (cmds !== 5'b00010) $display("FAIL pre_reset_rotate: got %b expected %b", cmds, 5'b00010);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (cmds !== 5'b00000) $display("FAIL async_clear: got %b expected %b", cmds, 5'b00000);
    else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    total_cnt++;
    if (cmds !== 5'b10010) $display("FAIL post_reset_press: got %b expected %b", cmds, 5'b10010);
    else pass_cnt++;
    for (int k = 1; k <= 21; k++) begin
      tick(a, b);
      total_cnt++;
      if (a[4] !== (k == 21) || b[4] !== 1'b0)
        $display("FAIL post_reset_timer tick %0d: got %b/%b expected %b/0", k, a[4], b[4], (k == 21));
      else pass_cnt++;
    end
    raw_left = 1'b0;
    raw_rotate = 1'b0;
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_rotate();
    test_left_das();
    test_left_repeat();
    test_release_resets_timer();
    test_independence();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
